// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result bus of the pipelined carry-select adder/subtractor.
// master: operand staging side (drives operands, accepts results).
// slave:  the adder itself.
interface pipelined_carry_select_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor.
// Rank 0 holds the conditioned operands (B inverted and carry-in forced to 1
// for subtraction). Stage k then resolves block k: it forms the block sum for
// carry-in 0 and 1 in parallel and picks one with the carry registered by the
// previous rank, passing the remaining operand bits and the finished lower sum
// bits forward. Rank NUM_BLOCKS is the output register. The whole pipe moves
// in lockstep: it advances when the output is empty or being taken, and
// otherwise freezes, bubbles included.
module pipelined_carry_select_adder #(
   parameter int WIDTH     = 32,
   parameter int BLOCK_LEN = 4
) (
   input logic                           clk,
   input logic                           rst_n,
   pipelined_carry_select_adder_if.slave bus
);

   localparam int NUM_BLOCKS = WIDTH / BLOCK_LEN;

   if ((WIDTH % BLOCK_LEN) != 0 || WIDTH < BLOCK_LEN) begin : g_bad_width
      $error("WIDTH must be a non-zero multiple of BLOCK_LEN");
   end

   // Ripple sum of one block: returns {carry out, sum}.
   function automatic logic [BLOCK_LEN:0] block_add(
      input logic [BLOCK_LEN-1:0] a,
      input logic [BLOCK_LEN-1:0] b,
      input logic                 cin
   );
      logic [BLOCK_LEN:0]   c;
      logic [BLOCK_LEN-1:0] s;
      c[0] = cin;
      for (int i = 0; i < BLOCK_LEN; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      return {c[BLOCK_LEN], s};
   endfunction

   logic                  adv;
   logic [NUM_BLOCKS:0]   v_q;                   // valid bit of each rank
   logic [NUM_BLOCKS:0]   c_q;                   // carry into the next block
   logic [WIDTH-1:0]      a_q     [NUM_BLOCKS];  // operand A still to consume
   logic [WIDTH-1:0]      b_q     [NUM_BLOCKS];  // conditioned operand B
   logic [WIDTH-1:0]      sum_q   [1:NUM_BLOCKS];// sum bits resolved so far
   logic                  cmsb_q;                // carry into the MSB

   logic [WIDTH-1:0]      sum_nxt [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] cout_nxt;
   logic                  cmsb_nxt;

   for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
      localparam int LO = k * BLOCK_LEN;

      logic [BLOCK_LEN:0] r0;
      logic [BLOCK_LEN:0] r1;
      logic [BLOCK_LEN:0] rs;
      logic [WIDTH-1:0]   base;

      assign r0 = block_add(a_q[k][LO +: BLOCK_LEN], b_q[k][LO +: BLOCK_LEN], 1'b0);
      assign r1 = block_add(a_q[k][LO +: BLOCK_LEN], b_q[k][LO +: BLOCK_LEN], 1'b1);
      assign rs = c_q[k] ? r1 : r0;

      if (k == 0) begin : g_first
         assign base = '0;
      end else begin : g_rest
         assign base = sum_q[k];
      end

      assign sum_nxt[k]  = (base & ~(WIDTH'({BLOCK_LEN{1'b1}}) << LO))
                         | (WIDTH'(rs[BLOCK_LEN-1:0]) << LO);
      assign cout_nxt[k] = rs[BLOCK_LEN];

      // The carry into the MSB falls out of sum = a ^ b ^ c at the top bit.
      if (k == NUM_BLOCKS - 1) begin : g_last
         assign cmsb_nxt = rs[BLOCK_LEN-1] ^ a_q[k][WIDTH-1] ^ b_q[k][WIDTH-1];
      end
   end

   assign adv = ~v_q[NUM_BLOCKS] | bus.out_ready;

   // Pipeline registers: shift every rank forward together when adv is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: only valid bits and the output rank are reset; inner operand
         // and partial-sum ranks are don't-care while their valid bit is low.
         v_q               <= '0;
         c_q[NUM_BLOCKS]   <= 1'b0;
         sum_q[NUM_BLOCKS] <= '0;
         cmsb_q            <= 1'b0;
      end else if (adv) begin
         // NOTE: non-blocking so each rank samples its predecessor's pre-edge value.
         v_q    <= {v_q[NUM_BLOCKS-1:0], bus.in_valid};
         c_q    <= {cout_nxt, bus.in_sub | bus.in_cin};
         a_q[0] <= bus.in_a;
         b_q[0] <= bus.in_sub ? ~bus.in_b : bus.in_b;
         for (int k = 1; k < NUM_BLOCKS; k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
         end
         for (int k = 0; k < NUM_BLOCKS; k++) begin
            sum_q[k+1] <= sum_nxt[k];
         end
         cmsb_q <= cmsb_nxt;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = v_q[NUM_BLOCKS];
   assign bus.out_sum   = sum_q[NUM_BLOCKS];
   assign bus.out_cout  = c_q[NUM_BLOCKS];
   assign bus.out_ovf   = c_q[NUM_BLOCKS] ^ cmsb_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for pipelined_carry_select_adder (WIDTH=16, BLOCK_LEN=4).
// Expected results are queued when a beat is accepted and compared when the
// matching result is taken; outputs are sampled on the falling edge.
module tb_pipelined_carry_select_adder;

   localparam int W  = 16;
   localparam int BL = 4;
   localparam int LATENCY = 5;  // falling edges from accept sample to result sample

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         chk_lat;
      int unsigned  cyc;
   } exp_t;

   logic clk;
   logic rst_n;

   pipelined_carry_select_adder_if #(.WIDTH(W)) bus ();

   pipelined_carry_select_adder #(
      .WIDTH     (W),
      .BLOCK_LEN (BL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc      = 0;
   int          out_cnt  = 0;
   exp_t        sb[$];
   exp_t        cur_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov,
                               input logic lat);
      exp_t e;
      e.sum     = s;
      e.cout    = co;
      e.ovf     = ov;
      e.chk_lat = lat;
      e.cyc     = 0;
      return e;
   endfunction

   // Reference: plain wide addition, carry into MSB from the lower W-1 bits.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input logic lat);
      logic [W-1:0] be;
      logic         c0;
      logic [W:0]   full;
      logic [W-1:0] low;
      be   = sub ? ~b : b;
      c0   = sub | cin;
      full = {1'b0, a} + {1'b0, be} + (W+1)'(c0);
      low  = {1'b0, a[W-2:0]} + {1'b0, be[W-2:0]} + W'(c0);
      return mk(full[W-1:0], full[W], full[W] ^ low[W-1], lat);
   endfunction

   // Monitor: stall stability, result scoreboard and accept tracking.
   logic         hold = 1'b0;
   logic [W-1:0] held_sum;
   logic         held_cout;
   logic         held_ovf;

   always @(negedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      if (hold) begin
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_sum",   32'(bus.out_sum),   32'(held_sum));
         check("stall_cout",  32'(bus.out_cout),  32'(held_cout));
         check("stall_ovf",   32'(bus.out_ovf),   32'(held_ovf));
      end
      if (!rst_n) begin
         sb.delete();
         hold = 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_out", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sum",  32'(bus.out_sum),  32'(e.sum));
               check("cout", 32'(bus.out_cout), 32'(e.cout));
               check("ovf",  32'(bus.out_ovf),  32'(e.ovf));
               if (e.chk_lat) check("latency", cyc - e.cyc, LATENCY);
            end
            out_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            e     = cur_exp;
            e.cyc = cyc;
            sb.push_back(e);
         end
         hold      = bus.out_valid && !bus.out_ready;
         held_sum  = bus.out_sum;
         held_cout = bus.out_cout;
         held_ovf  = bus.out_ovf;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
      int n;
      bit acc;
      cur_exp      = e;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
         n++;
      end
      if (!acc) check("drive_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drive_rand(input logic lat);
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      drive(a, b, cin, sub, model(a, b, cin, sub, lat));
   endtask

   task automatic wait_outs(input string tag, input int target);
      int n;
      n = 0;
      while (out_cnt < target && n < 200) begin
         step();
         n++;
      end
      check(tag, out_cnt, target);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = 16'hAAAA;
      bus.in_b      = 16'h5555;
      bus.in_cin    = 1'b1;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;
      cur_exp       = mk('0, 1'b0, 1'b0, 1'b0);

      // Reset held for two edges with a beat offered.
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sum",   32'(bus.out_sum),   32'd0);
      check("rst_out_cout",  32'(bus.out_cout),  32'd0);
      check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_stale", 32'(bus.out_valid), 32'd0);
      end
      step();

      // Directed boundary cases, back to back.
      base = out_cnt;
      drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b1));
      drive(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b1));
      drive(16'h0003, 16'h0005, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b1));
      drive(16'h0003, 16'h0005, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b1));
      drive(16'h1234, 16'h0001, 1'b1, 1'b0, mk(16'h1236, 1'b0, 1'b0, 1'b1));
      wait_outs("directed_count", base + 6);

      // Back-to-back random stream; constant latency implies one result per cycle.
      base = out_cnt;
      for (int i = 0; i < 20; i++) drive_rand(1'b1);
      wait_outs("stream_count", base + 20);

      // Backpressure: stall the output for three cycles mid-stream.
      base = out_cnt;
      fork
         begin
            for (int i = 0; i < 6; i++) drive_rand(1'b0);
         end
         begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
               step();
               n++;
            end
            check("bp_saw_valid", 32'(bus.out_valid), 32'd1);
            bus.out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            end
            step();
            bus.out_ready = 1'b1;
         end
      join
      wait_outs("bp_count", base + 6);

      // Reset with three operations in flight.
      base = out_cnt;
      for (int i = 0; i < 3; i++) drive_rand(1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_sum",   32'(bus.out_sum),   32'd0);
      step();
      check("rst_mid_discard", out_cnt, base);
      drive(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0, 1'b1));
      wait_outs("rst_mid_count", base + 1);
      repeat (6) step();
      check("sb_empty", sb.size(), 32'd0);
      check("final_count", out_cnt, base + 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
